// File: rtl/fifo_ptr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ptr_pkg
// Shared definitions for the asynchronous-FIFO pointer logic:
//   ptr_cfg_t     : pointer geometry (depth, pointer width, binary offset)
//   make_ptr_cfg  : derives the geometry from the FIFO depth
//   bin2gray      : binary -> reflected Gray code
//   gray2bin      : reflected Gray code -> binary
// The Gray helpers work on a fixed GMAX-bit container; callers size-cast
// their operands in and out.
// -----------------------------------------------------------------------------
package fifo_ptr_pkg;

    localparam int GMAX = 16;

    typedef struct packed {
        int depth;   // FIFO entries
        int pw;      // pointer width, one bit wider than the RAM address
        int off;     // start of the binary pointer window
    } ptr_cfg_t;

    // A non-power-of-two depth is handled by running the binary pointer over
    // a window centred in the 2**pw code space, so the Gray wrap from the top
    // of the window back to its bottom is still a single-bit change.
    function automatic ptr_cfg_t make_ptr_cfg(input int depth);
        ptr_cfg_t cfg;
        cfg.depth = depth;
        cfg.pw    = $clog2(depth) + 1;
        cfg.off   = (2 ** (cfg.pw - 1)) - depth;
        return cfg;
    endfunction

    function automatic logic [GMAX-1:0] bin2gray(input logic [GMAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GMAX-1:0] gray2bin(input logic [GMAX-1:0] gray);
        logic [GMAX-1:0] bin;
        bin[GMAX-1] = gray[GMAX-1];
        for (int i = GMAX - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wptr_gen_if.sv
// -----------------------------------------------------------------------------
// fifo_wptr_gen_if
// Write-side handshake bundle of the async-FIFO write pointer generator.
//   w_en         write request                     (master -> slave)
//   g_rptr_sync  Gray read pointer, in wclk domain  (master -> slave)
//   ovf_clr      clears the sticky overflow flag    (master -> slave)
//   g_wptr       Gray write pointer for read domain (slave -> master)
//   waddr        RAM write address                  (slave -> master)
//   wr_ack       write accepted this cycle          (slave -> master)
//   full / almost_full / wlevel / overflow          (slave -> master)
// The slave modport is the pointer generator; master is the write client.
// -----------------------------------------------------------------------------
interface fifo_wptr_gen_if #(
    parameter int DEPTH = 36
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic          w_en;
    logic [PW-1:0] g_rptr_sync;
    logic          ovf_clr;
    logic [PW-1:0] g_wptr;
    logic [AW-1:0] waddr;
    logic          wr_ack;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wlevel;
    logic          overflow;

    modport master (
        output w_en, g_rptr_sync, ovf_clr,
        input  g_wptr, waddr, wr_ack, full, almost_full, wlevel, overflow
    );

    modport slave (
        input  w_en, g_rptr_sync, ovf_clr,
        output g_wptr, waddr, wr_ack, full, almost_full, wlevel, overflow
    );

endinterface

// File: rtl/fifo_gray2bin.sv
// -----------------------------------------------------------------------------
// fifo_gray2bin
// Combinational reflected-Gray to binary decoder.
//   W       : code width
//   i_gray  : Gray-coded input
//   o_bin   : binary output; bit k is the XOR of all Gray bits k and above
// -----------------------------------------------------------------------------
module fifo_gray2bin #(
    parameter int W = 7
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Each output bit is an independent reduction, so there is no ripple
    // through o_bin itself.
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign o_bin[gi] = ^i_gray[W-1:gi];
    end

endmodule

// File: rtl/fifo_wptr_gen.sv
// -----------------------------------------------------------------------------
// fifo_wptr_gen
// Write-domain pointer generator for an asynchronous FIFO of arbitrary even
// depth. Keeps a binary write pointer that runs over OFF..OFF+2*DEPTH-1 so its
// Gray image wraps with a single-bit change, and derives the registered RAM
// address, fill level, full and almost-full flags.
//
// Parameters : DEPTH (even, 4..256), AF_THRESH (1..DEPTH, default DEPTH-4)
// Ports      : wclk      write clock
//              wrst_n    synchronous active-low reset
//              bus       fifo_wptr_gen_if.slave (w_en, g_rptr_sync, ovf_clr in;
//                        g_wptr, waddr, wr_ack, full, almost_full, wlevel,
//                        overflow out)
// Build macro: FIFO_WPTR_OVERFLOW_EN -- adds the sticky overflow register;
//              when undefined overflow is tied low and ovf_clr is ignored.
// -----------------------------------------------------------------------------
module fifo_wptr_gen
    import fifo_ptr_pkg::*;
#(
    parameter int DEPTH     = 36,
    parameter int AF_THRESH = DEPTH - 4
) (
    input  logic              wclk,
    input  logic              wrst_n,
    fifo_wptr_gen_if.slave    bus
);

    localparam ptr_cfg_t CFG = make_ptr_cfg(DEPTH);
    localparam int PW  = CFG.pw;
    localparam int AW  = $clog2(DEPTH);
    localparam int OFF = CFG.off;

    localparam logic [PW-1:0] B_FIRST = PW'(OFF);
    localparam logic [PW-1:0] B_LAST  = PW'(OFF + 2 * DEPTH - 1);
    localparam logic [PW-1:0] G_FIRST = PW'(bin2gray(GMAX'(B_FIRST)));

    // One extra bit so level arithmetic can add the 2*DEPTH span without loss.
    localparam logic [PW:0] OFF_E   = (PW+1)'(OFF);
    localparam logic [PW:0] LAST_E  = (PW+1)'(OFF + 2 * DEPTH - 1);
    localparam logic [PW:0] DEPTH_E = (PW+1)'(DEPTH);
    localparam logic [PW:0] SPAN_E  = (PW+1)'(2 * DEPTH);
    localparam logic [PW:0] AF_E    = (PW+1)'(AF_THRESH);

    logic [PW-1:0] r_b;
    logic [PW-1:0] r_g_wptr;
    logic [AW-1:0] r_waddr;
    logic [PW-1:0] r_wlevel;
    logic          r_full;
    logic          r_almost_full;

    logic          w_wr_ack;
    logic [PW-1:0] w_b_rptr;
    logic [PW-1:0] w_b_next;
    logic [PW:0]   w_b_next_e;
    logic [PW:0]   w_b_rptr_e;
    logic [PW:0]   w_level_next;
    logic [PW:0]   w_rel_next;
    logic [AW-1:0] w_waddr_next;

    fifo_gray2bin #(
        .W (PW)
    ) u_rptr_dec (
        .i_gray (bus.g_rptr_sync),
        .o_bin  (w_b_rptr)
    );

    // A write is refused purely on the registered full flag, so a read that
    // frees space in the same cycle only helps from the next cycle on.
    assign w_wr_ack = bus.w_en & ~r_full;

    assign w_b_next = !w_wr_ack        ? r_b     :
                      (r_b == B_LAST)  ? B_FIRST :
                                         r_b + 1'b1;

    assign w_b_next_e = {1'b0, w_b_next};
    assign w_b_rptr_e = {1'b0, w_b_rptr};

    // Distance modulo 2*DEPTH; both pointers live in the same offset window,
    // so the offset cancels and only the wrap needs correcting.
    assign w_level_next = (w_b_next_e >= w_b_rptr_e)
                        ? (w_b_next_e - w_b_rptr_e)
                        : (w_b_next_e + SPAN_E - w_b_rptr_e);

    assign w_rel_next   = w_b_next_e - OFF_E;
    assign w_waddr_next = AW'((w_rel_next >= DEPTH_E) ? (w_rel_next - DEPTH_E)
                                                      : w_rel_next);

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_b           <= B_FIRST;
            r_g_wptr      <= G_FIRST;
            r_waddr       <= '0;
            r_wlevel      <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
        end else begin
            r_b           <= w_b_next;
            r_g_wptr      <= PW'(bin2gray(GMAX'(w_b_next)));
            r_waddr       <= w_waddr_next;
            r_wlevel      <= PW'(w_level_next);
            r_full        <= (w_level_next == DEPTH_E);
            r_almost_full <= (w_level_next >= AF_E);
        end
    end

    // A read pointer outside the window means a broken synchroniser or a
    // mismatched read side; the level is meaningless from then on.
    always_ff @(posedge wclk) begin
        if (wrst_n) begin
            assert ((w_b_rptr_e >= OFF_E) && (w_b_rptr_e <= LAST_E))
            else $error("fifo_wptr_gen: g_rptr_sync decodes outside pointer window");
        end
    end

`ifdef FIFO_WPTR_OVERFLOW_EN
    logic r_overflow;

    // Setting wins over a clear in the same cycle so no rejected write is lost.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_overflow <= 1'b0;
        end else if (bus.w_en & r_full) begin
            r_overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.overflow = r_overflow;
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = bus.ovf_clr;
    assign bus.overflow     = 1'b0;
`endif

    assign bus.wr_ack      = w_wr_ack;
    assign bus.g_wptr      = r_g_wptr;
    assign bus.waddr       = r_waddr;
    assign bus.wlevel      = r_wlevel;
    assign bus.full        = r_full;
    assign bus.almost_full = r_almost_full;

endmodule

// File: tb/tb_fifo_wptr_gen.sv
// -----------------------------------------------------------------------------
// tb_fifo_wptr_gen
// Scoreboard bench for fifo_wptr_gen at DEPTH=36 (PW=7, OFF=28, AF=32).
// The stimulus process drives one cycle at a time and pushes the expected
// outputs for that cycle; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_fifo_wptr_gen;

    localparam int DEPTH = 36;
    localparam int PW    = 7;
    localparam int OFF   = 28;
    localparam int SPAN  = 72;
    localparam int AF    = 32;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;

    fifo_wptr_gen_if #(.DEPTH(DEPTH)) bus ();

    fifo_wptr_gen #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus.slave)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        bit chk_ack;
        bit normal;     // previous edge was not a reset edge
        int gw, wa, lvl, full, af, ovf, ack;
        int hand_gw;    // -1: no hand value
        int hand_lvl;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    int   wraps  = 0;
    int   prev_gw = -1;

    // reference model state
    int m_b, m_wa, m_lvl;
    bit m_full, m_af, m_ovf;
    bit m_last_rst = 1'b0;
    int rd_b = OFF;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s txn=%0d actual=%0d expected=%0d", name, txn, act, exp);
        end
    endtask

    task automatic model_reset();
        m_b = OFF; m_wa = 0; m_lvl = 0;
        m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    endtask

    // One clock cycle: drive, push expectation, take the edge, advance model.
    task automatic step(input bit rst_i, input bit wen, input bit clr,
                        input bit adv_r, input int hand_gw = -1,
                        input int hand_lvl = -1);
        exp_t e;
        bit   ack;
        bit   ovf_set;
        if (adv_r) rd_b = (rd_b == OFF + SPAN - 1) ? OFF : rd_b + 1;
        wrst_n          = rst_i;
        bus.w_en        = wen;
        bus.ovf_clr     = clr;
        bus.g_rptr_sync = PW'(gray(rd_b));
        ack = wen && !m_full;
        e.chk_ack  = 1'b1;
        e.normal   = m_last_rst;
        e.gw       = gray(m_b);
        e.wa       = m_wa;
        e.lvl      = m_lvl;
        e.full     = int'(m_full);
        e.af       = int'(m_af);
        e.ovf      = int'(m_ovf);
        e.ack      = int'(ack);
        e.hand_gw  = hand_gw;
        e.hand_lvl = hand_lvl;
        q.push_back(e);
        @(posedge wclk);
        if (!rst_i) begin
            model_reset();
        end else begin
            ovf_set = wen && m_full;
            if (ack) m_b = (m_b == OFF + SPAN - 1) ? OFF : m_b + 1;
            m_lvl  = (m_b - rd_b + SPAN) % SPAN;
            m_wa   = (m_b - OFF) % DEPTH;
            m_full = (m_lvl == DEPTH);
            m_af   = (m_lvl >= AF);
`ifdef FIFO_WPTR_OVERFLOW_EN
            if (ovf_set) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
`else
            if (ovf_set && clr) m_ovf = 1'b0;
`endif
        end
        m_last_rst = rst_i;
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the queued record.
    always @(negedge wclk) begin
        if (q.size() > 0) begin
            exp_t e;
            int   cur_gw;
            e = q.pop_front();
            txn++;
            cur_gw = int'(bus.g_wptr);
            $display("txn %0d gw=%02h wa=%0d lvl=%0d full=%0d af=%0d ovf=%0d ack=%0d",
                     txn, cur_gw, bus.waddr, bus.wlevel, bus.full,
                     bus.almost_full, bus.overflow, bus.wr_ack);
            cmp("g_wptr", cur_gw, e.gw);
            cmp("waddr", int'(bus.waddr), e.wa);
            cmp("wlevel", int'(bus.wlevel), e.lvl);
            cmp("full", int'(bus.full), e.full);
            cmp("almost_full", int'(bus.almost_full), e.af);
            cmp("overflow", int'(bus.overflow), e.ovf);
            if (e.chk_ack)       cmp("wr_ack", int'(bus.wr_ack), e.ack);
            if (e.hand_gw >= 0)  cmp("g_wptr_hand", cur_gw, e.hand_gw);
            if (e.hand_lvl >= 0) cmp("wlevel_hand", int'(bus.wlevel), e.hand_lvl);
            if (e.normal && prev_gw >= 0)
                cmp("gray_one_bit", int'($countones(7'(prev_gw ^ cur_gw)) <= 1), 1);
            if (e.normal && prev_gw == 'h52 && cur_gw != 'h52) begin
                wraps++;
                cmp("wrap_gw", cur_gw, 'h12);
                cmp("wrap_waddr", int'(bus.waddr), 0);
            end
            prev_gw = cur_gw;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // First reset edge, before any record is queued.
        wrst_n          = 1'b0;
        bus.w_en        = 1'b1;
        bus.ovf_clr     = 1'b0;
        bus.g_rptr_sync = PW'(gray(OFF));
        @(posedge wclk);
        model_reset();
        #1;

        // Reset held a second cycle with w_en high, then released.
        step(1'b0, 1'b1, 1'b0, 1'b0, 'h12, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 'h12, 0);

        // Fill: 37 write requests, read pointer fixed at 0x12.
        for (int i = 0; i < 37; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, -1, (i > 36) ? 36 : i);
        step(1'b1, 1'b0, 1'b0, 1'b0, 'h60, 36);

        // Full, read advances with a write pending: rejected, then accepted.
        step(1'b1, 1'b1, 1'b0, 1'b1, -1, 36);
        step(1'b1, 1'b1, 1'b0, 1'b0, -1, 35);
        step(1'b1, 1'b0, 1'b0, 1'b0, -1, 36);

        // Writes while full, clear pulse, and set-beats-clear.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Streaming with matching reads across the pointer wrap.
        for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 1'b0, 1'b1);

        // Drain, then fill to 20 and reset mid-operation.
        for (int i = 0; i < 40 && m_lvl > 0; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, -1, 0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, -1, 20);
        rd_b = OFF;
        step(1'b0, 1'b1, 1'b0, 1'b0, -1, 20);
        step(1'b1, 1'b0, 1'b0, 1'b0, 'h12, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, -1, 3);

        @(negedge wclk);
        #1;
        cmp("wrap_seen", int'(wraps >= 1), 1);
        cmp("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
